hazard_unit_v2: RTL and testbench

//  Parametrised pipeline hazard controller for the in-order core. Generalises

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_unit_v2_scoreboard.sv | 62 ++++++
 rtl/hazard_unit_v2.sv | 119 +++++++++++
 tb/tb_hazard_unit_v2.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int FLUSH_CW = 3;
  localparam int RD_MAXW  = 8;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  typedef struct packed {
    logic               v;
    logic [RD_MAXW-1:0] rd;
    logic               ld;
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_v2_scoreboard.sv
// In-flight producer shift register with priority bypass select and load-use detect.
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = sel_w(FWD_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adv_i,
  input  logic              flush_i,
  input  logic              dst_en_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              is_load_i,
  output logic [SEL_W-1:0]  src1_sel_o,
  output logic [SEL_W-1:0]  src2_sel_o,
  output logic              ldhaz_o
);

  sb_entry_t            sb_q [FWD_DEPTH];
  sb_entry_t            ins_d;
  logic [FWD_DEPTH-1:0] hit1;
  logic [FWD_DEPTH-1:0] hit2;

  for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_cmp
    assign hit1[gi] = sb_q[gi].v & (sb_q[gi].rd == RD_MAXW'(rs1_i)) & (rs1_i != '0);
    assign hit2[gi] = sb_q[gi].v & (sb_q[gi].rd == RD_MAXW'(rs2_i)) & (rs2_i != '0);
  end

  assign ldhaz_o = sb_q[0].v & sb_q[0].ld & (hit1[0] | hit2[0]);

  // A stalled load-use consumer inserts a bubble rather than itself.
  always_comb begin
    ins_d    = '0;
    ins_d.v  = dst_en_i & (rd_i != '0) & ~flush_i & ~ldhaz_o;
    ins_d.rd = RD_MAXW'(rd_i);
    ins_d.ld = is_load_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb_q[k] <= '0;
    end else if (adv_i) begin
      sb_q[0] <= ins_d;
      for (int k = 1; k < FWD_DEPTH; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  // Scan from the oldest entry so the youngest match wins.
  always_comb begin
    src1_sel_o = '0;
    src2_sel_o = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hit1[k]) src1_sel_o = SEL_W'(k + 1);
      if (hit2[k]) src2_sel_o = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/hazard_unit_v2.sv
// Pipeline hazard controller: bypass selects, load-use/mul-div/cache stalls, flush windows.
module hazard_unit_v2
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int JMP_FLUSH = 2,
  parameter int BR_FLUSH  = 2,
  parameter int SEL_W     = sel_w(FWD_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_dst_en_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_is_load_i,
  input  logic              id_is_jump_i,
  input  logic              id_is_br_i,
  input  logic              id_is_md_i,
  input  logic              bp_taken_i,
  input  logic              ex_taken_i,
  input  logic              md_done_i,
  input  logic              ic_miss_i,
  input  logic              ic_arr_i,
  input  logic              dc_miss_i,
  input  logic              dc_arr_i,
  output logic [SEL_W-1:0]  src1_sel_o,
  output logic [SEL_W-1:0]  src2_sel_o,
  output logic              fd_st_o,
  output logic              de_st_o,
  output logic              em_st_o,
  output logic              flush_o
);

  localparam logic [FLUSH_CW-1:0] JMP_LD = FLUSH_CW'(JMP_FLUSH);
  localparam logic [FLUSH_CW-1:0] BR_LD  = FLUSH_CW'(BR_FLUSH - 1);

  md_state_t           md_q;
  logic                ic_flag_q, dc_flag_q;
  logic                br_v_q, br_pred_q;
  logic [FLUSH_CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [SEL_W-1:0]    sel1, sel2;
  logic                ldhaz, ic_st, dc_st, md_st, mispred, flush;

  assign ic_st   = (ic_miss_i | ic_flag_q) & ~ic_arr_i;
  assign dc_st   = (dc_miss_i | dc_flag_q) & ~dc_arr_i;
  assign md_st   = (md_q == MD_BUSY) & ~md_done_i;
  assign mispred = br_v_q & (ex_taken_i != br_pred_q);
  assign flush   = (flush_cnt_q != '0) | mispred;

  hz_scoreboard #(
    .REG_AW    (REG_AW),
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .adv_i      (~dc_st),
    .flush_i    (flush),
    .dst_en_i   (id_dst_en_i),
    .rd_i       (id_rd_i),
    .rs1_i      (id_rs1_i),
    .rs2_i      (id_rs2_i),
    .is_load_i  (id_is_load_i),
    .src1_sel_o (sel1),
    .src2_sel_o (sel2),
    .ldhaz_o    (ldhaz)
  );

  // Overlapping windows keep whichever has the most cycles left.
  always_comb begin
    flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - 1'b1 : '0;
    if (id_is_jump_i && !flush && (JMP_LD > flush_cnt_d)) flush_cnt_d = JMP_LD;
    if (mispred && (BR_LD > flush_cnt_d)) flush_cnt_d = BR_LD;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      flush_cnt_q <= '0;
      br_v_q      <= 1'b0;
      br_pred_q   <= 1'b0;
    end else if (!dc_st) begin
      flush_cnt_q <= flush_cnt_d;
      br_v_q      <= id_is_br_i & ~flush;
      br_pred_q   <= bp_taken_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ic_flag_q <= 1'b0;
      dc_flag_q <= 1'b0;
    end else begin
      ic_flag_q <= (ic_flag_q | ic_miss_i) & ~ic_arr_i;
      dc_flag_q <= (dc_flag_q | dc_miss_i) & ~dc_arr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      md_q <= MD_IDLE;
    end else begin
      case (md_q)
        MD_IDLE: if (id_is_md_i && !flush && !dc_st) md_q <= MD_BUSY;
        MD_BUSY: if (md_done_i) md_q <= MD_IDLE;
        default: md_q <= MD_IDLE;
      endcase
    end
  end

  assign src1_sel_o = rstn ? sel1 : '0;
  assign src2_sel_o = rstn ? sel2 : '0;
  assign fd_st_o    = rstn & (ic_st | dc_st | ldhaz | md_st);
  assign de_st_o    = rstn & (ldhaz | dc_st | md_st);
  assign em_st_o    = rstn & dc_st;
  assign flush_o    = rstn & flush;

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed-vector self-checking bench for hazard_unit_v2 with default parameters.
module tb_hazard_unit_v2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_dst_en, id_is_load, id_is_jump, id_is_br, id_is_md;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       bp_taken, ex_taken, md_done, ic_miss, ic_arr, dc_miss, dc_arr;
  logic [1:0] src1_sel, src2_sel;
  logic       fd_st, de_st, em_st, flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_v2 dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_dst_en_i  (id_dst_en),
    .id_rd_i      (id_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_is_load_i (id_is_load),
    .id_is_jump_i (id_is_jump),
    .id_is_br_i   (id_is_br),
    .id_is_md_i   (id_is_md),
    .bp_taken_i   (bp_taken),
    .ex_taken_i   (ex_taken),
    .md_done_i    (md_done),
    .ic_miss_i    (ic_miss),
    .ic_arr_i     (ic_arr),
    .dc_miss_i    (dc_miss),
    .dc_arr_i     (dc_arr),
    .src1_sel_o   (src1_sel),
    .src2_sel_o   (src2_sel),
    .fd_st_o      (fd_st),
    .de_st_o      (de_st),
    .em_st_o      (em_st),
    .flush_o      (flush)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
    end
  endtask

  task automatic idle();
    id_dst_en = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_is_load = 0; id_is_jump = 0; id_is_br = 0; id_is_md = 0;
    bp_taken = 0; ex_taken = 0; md_done = 0;
    ic_miss = 0; ic_arr = 0; dc_miss = 0; dc_arr = 0;
  endtask

  task automatic op(input logic en, input int rd, input int rs1, input int rs2, input logic ld);
    idle();
    id_dst_en = en; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_is_load = ld;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled on the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input int f, input int d, input int e);
    chk({tag, ".fd_st"}, int'(fd_st), f);
    chk({tag, ".de_st"}, int'(de_st), d);
    chk({tag, ".em_st"}, int'(em_st), e);
  endtask

  initial begin
    // Reset with active inputs: every output must read 0
    idle();
    rstn = 0; dc_miss = 1; ic_miss = 1; id_is_jump = 1;
    settle();
    chk_st("rst", 0, 0, 0);
    chk("rst.flush", int'(flush), 0);
    adv();
    idle();
    settle();
    adv();
    rstn = 1;

    // Bypass distance: 1, 2, then aged out
    op(1, 5, 1, 2, 0); settle(); chk("fwd.a.sel1", int'(src1_sel), 0); adv();
    op(1, 6, 5, 0, 0); settle(); chk("fwd.b.sel1", int'(src1_sel), 1);
    chk("fwd.b.sel2", int'(src2_sel), 0); adv();
    op(0, 0, 0, 0, 0); settle(); adv();
    op(0, 0, 6, 5, 0); settle(); chk("fwd.gap.sel1", int'(src1_sel), 2);
    chk("fwd.old.sel2", int'(src2_sel), 0); adv();

    // Load-use: one-cycle stall, then forward from entry 2
    op(1, 7, 1, 0, 1); settle(); chk_st("lw", 0, 0, 0); adv();
    op(1, 8, 1, 7, 0); settle(); chk_st("ldu", 1, 1, 0); adv();
    op(1, 8, 1, 7, 0); settle(); chk_st("ldu2", 0, 0, 0);
    chk("ldu2.sel2", int'(src2_sel), 2); chk("ldu2.sel1", int'(src1_sel), 0); adv();
    op(1, 0, 0, 0, 1); settle(); adv();
    op(0, 0, 0, 8, 0); settle(); chk_st("ldx0", 0, 0, 0);
    chk("ldx0.sel2", int'(src2_sel), 2); adv();

    // Jump flush window; second jump inside it is ignored
    idle(); settle(); adv();
    idle(); id_is_jump = 1; settle(); chk("jmp.t0", int'(flush), 0); adv();
    idle(); id_is_jump = 1; settle(); chk("jmp.t1", int'(flush), 1); adv();
    idle(); settle(); chk("jmp.t2", int'(flush), 1); adv();
    idle(); settle(); chk("jmp.t3", int'(flush), 0); adv();

    // Branch mispredict, then correct prediction
    idle(); id_is_br = 1; bp_taken = 0; settle(); chk("br.t0", int'(flush), 0); adv();
    idle(); ex_taken = 1; settle(); chk("br.t1", int'(flush), 1); adv();
    idle(); settle(); chk("br.t2", int'(flush), 1); adv();
    idle(); settle(); chk("br.t3", int'(flush), 0); adv();
    idle(); id_is_br = 1; bp_taken = 1; settle(); adv();
    idle(); ex_taken = 1; settle(); chk("brok.t1", int'(flush), 0); adv();
    idle(); settle(); chk("brok.t2", int'(flush), 0); adv();

    // Mul/div: five busy cycles before md_done
    idle(); id_is_md = 1; settle(); chk_st("md.t0", 0, 0, 0); adv();
    for (int i = 1; i <= 5; i++) begin
      idle(); settle(); chk_st($sformatf("md.t%0d", i), 1, 1, 0); adv();
    end
    idle(); md_done = 1; settle(); chk_st("md.done", 0, 0, 0); adv();
    idle(); settle(); chk_st("md.idle", 0, 0, 0); adv();

    // D-cache miss: 3-cycle em_st with the scoreboard frozen
    op(1, 10, 0, 0, 0); settle(); adv();
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 10, 0, 0); dc_miss = (i == 0); settle();
      chk_st($sformatf("dc.t%0d", i), 1, 1, 1);
      chk($sformatf("dc.t%0d.sel1", i), int'(src1_sel), 1); adv();
    end
    op(0, 0, 10, 0, 0); dc_arr = 1; settle(); chk_st("dc.arr", 0, 0, 0);
    chk("dc.arr.sel1", int'(src1_sel), 1); adv();
    op(0, 0, 10, 0, 0); settle(); chk("dc.post.sel1", int'(src1_sel), 2); adv();
    idle(); dc_miss = 1; dc_arr = 1; settle(); chk_st("dcsame", 0, 0, 0); adv();
    idle(); settle(); chk_st("dcsame.n", 0, 0, 0); adv();
    idle(); ic_miss = 1; settle(); chk_st("ic.t0", 1, 0, 0); adv();
    idle(); settle(); chk_st("ic.t1", 1, 0, 0); adv();
    idle(); ic_arr = 1; settle(); chk_st("ic.arr", 0, 0, 0); adv();
    idle(); ic_miss = 1; ic_arr = 1; settle(); chk_st("icsame", 0, 0, 0); adv();

    // Reset while BUSY with an active flush window and a live producer
    op(1, 11, 0, 0, 0); id_is_md = 1; id_is_jump = 1; settle(); adv();
    idle(); settle(); chk_st("pre.busy", 1, 1, 0); chk("pre.flush", int'(flush), 1);
    rstn = 0; settle(); chk_st("rst2", 0, 0, 0); chk("rst2.flush", int'(flush), 0); adv();
    rstn = 1;
    op(0, 0, 11, 0, 0); settle(); chk_st("rst2.n", 0, 0, 0);
    chk("rst2.n.flush", int'(flush), 0); chk("rst2.n.sel1", int'(src1_sel), 0); adv();
    idle(); settle(); chk_st("rst2.n2", 0, 0, 0); chk("rst2.n2.flush", int'(flush), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
